// File: rtl/card_deal_arbiter.sv
// Arbitrates six card-slot load requests onto one card source, one draw at a time.
// Optional build macro CARD_RANGE_CHECK_EN discards drawn ranks outside 1..13 and redraws.
module card_deal_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic       i_clk,
  input  logic       i_resetb,
  input  logic [5:0] i_req,
  input  logic       i_round_clr,
  input  logic [3:0] i_src_card,
  input  logic       i_src_valid,
  output logic       o_src_next,
  output logic [5:0] o_ack,
  output logic [5:0] o_slot_we,
  output logic [3:0] o_slot_data,
  output logic       o_busy,
  output logic [2:0] o_deal_count,
  output logic       o_dup_err,
  output logic       o_timeout_err
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_WRITE} state_t;

  state_t        r_state;
  logic [5:0]    r_grant;
  logic [5:0]    r_served;
  logic [CW-1:0] r_wait;
  logic [3:0]    r_card;
  logic          r_src_next;
  logic [5:0]    r_ack;
  logic [5:0]    r_slot_we;
  logic          r_busy;
  logic [2:0]    r_deal_count;
  logic          r_dup_err;
  logic          r_timeout_err;

  logic [5:0]    w_eligible;
  logic          w_dup;
  logic          w_card_ok;

  // Lowest set bit wins: deal order is pcard1, dcard1, pcard2, ...
  function automatic logic [5:0] lowest_bit(input logic [5:0] v);
    return v & (~v + 6'd1);
  endfunction

  function automatic logic [2:0] sat_inc6(input logic [2:0] c);
    return (c >= 3'd6) ? 3'd6 : c + 3'd1;
  endfunction

`ifdef CARD_RANGE_CHECK_EN
  function automatic logic rank_in_range(input logic [3:0] c);
    return (c >= 4'd1) && (c <= 4'd13);
  endfunction
  assign w_card_ok = rank_in_range(i_src_card);
`else
  assign w_card_ok = 1'b1;
`endif

  assign w_eligible = i_req & ~r_served;
  assign w_dup      = |(i_req & r_served);

  always_ff @(posedge i_clk) begin
    if (i_resetb) begin
      r_state       <= S_IDLE;
      r_grant       <= '0;
      r_served      <= '0;
      r_wait        <= '0;
      r_card        <= '0;
      r_src_next    <= 1'b0;
      r_ack         <= '0;
      r_slot_we     <= '0;
      r_busy        <= 1'b0;
      r_deal_count  <= '0;
      r_dup_err     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_src_next <= 1'b0;
      r_ack      <= '0;
      r_slot_we  <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_dup) r_dup_err <= 1'b1;
          if (|w_eligible) begin
            r_grant    <= lowest_bit(w_eligible);
            r_state    <= S_REQ;
            r_src_next <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        S_REQ: begin
          r_wait  <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (i_src_valid) begin
            if (w_card_ok) begin
              r_card    <= i_src_card;
              r_slot_we <= r_grant;
              r_ack     <= r_grant;
              r_state   <= S_WRITE;
            end else begin
              // Out-of-range rank: redraw for the same grant, not a timeout.
              r_state    <= S_REQ;
              r_src_next <= 1'b1;
            end
          end else if (r_wait == CW'(TIMEOUT)) begin
            r_timeout_err <= 1'b1;
            r_state       <= S_REQ;
            r_src_next    <= 1'b1;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        S_WRITE: begin
          r_served     <= r_served | r_grant;
          r_deal_count <= sat_inc6(r_deal_count);
          r_grant      <= '0;
          r_state      <= S_IDLE;
          r_busy       <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
      // A new round overrides the bookkeeping of a write landing on the same edge.
      if (i_round_clr) begin
        r_served     <= '0;
        r_deal_count <= '0;
      end
    end
  end

  assign o_src_next    = r_src_next;
  assign o_ack         = r_ack;
  assign o_slot_we     = r_slot_we;
  assign o_slot_data   = r_card;
  assign o_busy        = r_busy;
  assign o_deal_count  = r_deal_count;
  assign o_dup_err     = r_dup_err;
  assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_card_deal_arbiter.sv
// Directed bench for card_deal_arbiter: reset, full deal, duplicates, timeout, range check, mid-transaction reset/clear.
module tb_card_deal_arbiter;

  logic       clk = 1'b0;
  logic       resetb;
  logic [5:0] req;
  logic       round_clr;
  logic [3:0] src_card;
  logic       src_valid;
  logic       src_next;
  logic [5:0] ack;
  logic [5:0] slot_we;
  logic [3:0] slot_data;
  logic       busy;
  logic [2:0] deal_count;
  logic       dup_err;
  logic       timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  card_deal_arbiter #(.TIMEOUT(15)) dut (
    .i_clk        (clk),
    .i_resetb     (resetb),
    .i_req        (req),
    .i_round_clr  (round_clr),
    .i_src_card   (src_card),
    .i_src_valid  (src_valid),
    .o_src_next   (src_next),
    .o_ack        (ack),
    .o_slot_we    (slot_we),
    .o_slot_data  (slot_data),
    .o_busy       (busy),
    .o_deal_count (deal_count),
    .o_dup_err    (dup_err),
    .o_timeout_err(timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until src_next is seen (bounded); k = cycles waited.
  task automatic wait_next(output int k);
    k = 0;
    while (!src_next && k < 60) begin
      tick();
      k++;
    end
    check("src_next_seen", {31'd0, src_next}, 32'd1);
  endtask

  // Called in the src_next cycle; presents the rank in the following cycle.
  // Returns in the cycle after the rank was sampled (WRITE, or REQ on discard).
  task automatic deliver(input logic [3:0] rank);
    tick();
    src_valid = 1'b1;
    src_card  = rank;
    tick();
    src_valid = 1'b0;
    src_card  = 4'd0;
  endtask

  logic [3:0] ranks [6] = '{4'd5, 4'd9, 4'd1, 4'd13, 4'd2, 4'd7};

  initial begin
    int k;
    resetb    = 1'b1;
    req       = 6'b111111;
    round_clr = 1'b0;
    src_card  = 4'd0;
    src_valid = 1'b0;
    tick();
    tick();
    check("rst_src_next", {31'd0, src_next}, 32'd0);
    check("rst_ack", {26'd0, ack}, 32'd0);
    check("rst_slot_we", {26'd0, slot_we}, 32'd0);
    check("rst_slot_data", {28'd0, slot_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_deal_count", {29'd0, deal_count}, 32'd0);
    check("rst_dup_err", {31'd0, dup_err}, 32'd0);
    check("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
    resetb = 1'b0;

    // Full deal; each requester drops its request once acked.
    for (int i = 0; i < 6; i++) begin
      wait_next(k);
      check("grant_to_src_next", k, 32'd1);
      check("busy_in_req", {31'd0, busy}, 32'd1);
      deliver(ranks[i]);
      check("deal_slot_we", {26'd0, slot_we}, 32'd1 << i);
      check("deal_ack", {26'd0, ack}, 32'd1 << i);
      check("deal_slot_data", {28'd0, slot_data}, {28'd0, ranks[i]});
      req[i] = 1'b0;
      tick();
      check("deal_count_inc", {29'd0, deal_count}, i + 1);
      check("deal_ack_one_cycle", {26'd0, ack}, 32'd0);
    end
    check("deal_dup_err_clear", {31'd0, dup_err}, 32'd0);
    check("deal_busy_idle", {31'd0, busy}, 32'd0);

    // Duplicate request on an already-dealt slot.
    req = 6'b000001;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("dup_no_src_next", {31'd0, src_next}, 32'd0);
    end
    check("dup_err_set", {31'd0, dup_err}, 32'd1);
    check("dup_busy", {31'd0, busy}, 32'd0);
    round_clr = 1'b1;
    tick();
    round_clr = 1'b0;
    check("clr_deal_count", {29'd0, deal_count}, 32'd0);
    wait_next(k);
    check("redeal_latency", k, 32'd1);
    deliver(4'd3);
    check("redeal_slot_we", {26'd0, slot_we}, 32'd1);
    check("redeal_slot_data", {28'd0, slot_data}, 32'd3);
    req = 6'b000000;
    tick();
    check("redeal_count", {29'd0, deal_count}, 32'd1);
    check("dup_err_sticky", {31'd0, dup_err}, 32'd1);

    // Timeout and redraw.
    req = 6'b000010;
    wait_next(k);
    check("to_err_before", {31'd0, timeout_err}, 32'd0);
    k = 0;
    do begin
      tick();
      k++;
    end while (!src_next && k < 40);
    check("to_redraw_gap", k, 32'd17);
    check("to_err_set", {31'd0, timeout_err}, 32'd1);
    deliver(4'd4);
    check("to_slot_we", {26'd0, slot_we}, 32'd2);
    check("to_slot_data", {28'd0, slot_data}, 32'd4);
    req = 6'b000000;
    tick();
    check("to_count", {29'd0, deal_count}, 32'd2);

    // Rank range handling.
    req = 6'b000100;
    wait_next(k);
`ifdef CARD_RANGE_CHECK_EN
    deliver(4'd0);
    check("rng_redraw_0", {31'd0, src_next}, 32'd1);
    check("rng_no_we_0", {26'd0, slot_we}, 32'd0);
    deliver(4'd14);
    check("rng_redraw_14", {31'd0, src_next}, 32'd1);
    deliver(4'd6);
    check("rng_slot_we", {26'd0, slot_we}, 32'd4);
    check("rng_slot_data", {28'd0, slot_data}, 32'd6);
`else
    deliver(4'd0);
    check("rng_slot_we", {26'd0, slot_we}, 32'd4);
    check("rng_slot_data", {28'd0, slot_data}, 32'd0);
`endif
    req = 6'b000000;
    tick();
    check("rng_count", {29'd0, deal_count}, 32'd3);

    // Reset in WAIT.
    req = 6'b001000;
    wait_next(k);
    tick();
    check("mid_busy_wait", {31'd0, busy}, 32'd1);
    resetb = 1'b1;
    tick();
    resetb = 1'b0;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_slot_we", {26'd0, slot_we}, 32'd0);
    check("mid_rst_count", {29'd0, deal_count}, 32'd0);
    check("mid_rst_to_err", {31'd0, timeout_err}, 32'd0);
    check("mid_rst_dup_err", {31'd0, dup_err}, 32'd0);

    // round_clr landing in the WRITE cycle.
    wait_next(k);
    check("clrw_latency", k, 32'd1);
    deliver(4'd11);
    round_clr = 1'b1;
    req       = 6'b000000;
    check("clrw_ack", {26'd0, ack}, 32'd8);
    check("clrw_slot_data", {28'd0, slot_data}, 32'd11);
    tick();
    round_clr = 1'b0;
    check("clrw_count", {29'd0, deal_count}, 32'd0);
    check("clrw_busy", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation watchdog expired");
  end

endmodule

// File: doc/card_deal_arbiter.md
# card_deal_arbiter

Shares the single card source (the free-running rank counter) among the six card-slot load requests raised by the game sequencer: player cards 1–3 and dealer cards 1–3. It grants one request at a time and issues a draw handshake to the source. It then writes the captured rank into the granted slot register and acknowledges the requester. It sits between the game FSM and the card registers and score logic, and tracks which slots have been dealt in the current round.

## Interface
Parameters:
- TIMEOUT, 15: maximum cycles spent in WAIT for src_valid before a redraw.

Ports:
- clk  in  1  rising-edge clock.
- resetb  in  1  reset, synchronous, active-high.
- req  in  6  level load requests; bit order [0]=pcard1, [1]=dcard1, [2]=pcard2, [3]=dcard2, [4]=pcard3, [5]=dcard3.
- round_clr  in  1  one-cycle pulse that starts a new round.
- src_card  in  4  rank from the card source.
- src_valid  in  1  src_card is valid this cycle.
- src_next  out  1  one-cycle draw request to the card source.
- ack  out  6  one-hot, one-cycle acknowledge for the served request.
- slot_we  out  6  one-hot, one-cycle write enable for the card registers.
- slot_data  out  4  rank to write, valid when slot_we≠0.
- busy  out  1  high in every state except IDLE.
- deal_count  out  3  number of slots dealt this round; saturates at 6.
- dup_err  out  1  sticky; set when a request targets an already-served slot.
- timeout_err  out  1  sticky; set on any WAIT timeout.

## Operation
- States: IDLE, REQ, WAIT, WRITE.
- IDLE: form eligible = req & ~served. If eligible≠0, latch the lowest-index set bit into grant (fixed priority matching deal order) and go to REQ. Otherwise stay in IDLE.
- Duplicate request: if req & served ≠ 0 in IDLE, set dup_err. That request is never granted.
- REQ: drive src_next=1 for exactly this cycle, clear the wait counter, go to WAIT.
- WAIT:
  - On src_valid=1, capture src_card into the card register and go to WRITE.
  - Otherwise increment the wait counter. When it reaches TIMEOUT, set timeout_err and go to REQ (redraw).
- WRITE:
  - slot_we=grant, ack=grant, slot_data=captured card.
  - Set served bit for the grant.
  - deal_count += 1, saturating at 6.
  - Clear grant and go to IDLE.
- The grant is held from IDLE exit until WRITE completes. Deasserting the granted req mid-transaction does not abort it; the slot is still written and acked.
- round_clr clears served and deal_count at the clock edge. If round_clr coincides with WRITE, the write and ack still occur, and the clear wins: served=0, deal_count=0. round_clr does not clear the error flags and does not abort an in-flight transaction.
- Synchronous reset (resetb=1) returns to IDLE from any state, including mid-transaction.
  - All outputs reset to 0: src_next, ack, slot_we, slot_data, busy, deal_count, dup_err, timeout_err.
  - Internal grant, served, wait counter and card register also reset to 0.

## Timing
- Request sampled in IDLE at edge N → src_next high in cycle N+1.
- src_valid present in the cycle after src_next → slot_we/ack high in cycle N+3. This is the minimum latency: 3 cycles.
- Back-to-back service: the next grant is taken in IDLE in cycle N+4. Each card costs at least 4 cycles.
- Outputs src_next, ack, slot_we and busy are decoded from state and registers (Moore), with no combinational path from inputs.
- src_valid asserted during REQ or IDLE is ignored.

## Configuration
- CARD_RANGE_CHECK_EN defined:
  - In WAIT, a valid src_card outside 1..13 (0, 14, 15) is discarded and the FSM returns to REQ to redraw.
  - A discarded card does not set timeout_err and does not reset the transaction's grant.
- CARD_RANGE_CHECK_EN undefined: any valid src_card is written unchanged.

## Test plan
- Reset: resetb=1 for 2 cycles with req=6'b111111 → all outputs 0, state IDLE; after release, first ack is 6'b000001.
- Full deal: hold req=6'b111111 and return src_valid one cycle after each src_next with ranks 5,9,1,13,2,7 → slot_we order [0]..[5], ack 3 cycles after each grant, deal_count ends at 6, dup_err=0.
- Duplicate: after pcard1 served, assert req[0] again → no src_next, dup_err=1. round_clr pulse then re-request → pcard1 is re-dealt.
- Timeout: never assert src_valid with TIMEOUT=15 → timeout_err=1, a second src_next 17 cycles after the first; src_valid=1 with rank 4 then → slot written with 4.
- Range check (macro defined): src_card=0 then 14 then 6 → three src_next pulses, slot_data=6. With macro undefined, slot_data=0 on the first draw.
- Mid-transaction reset/clear:
  - resetb in WAIT → no slot_we, IDLE next cycle.
  - round_clr in the WRITE cycle → ack still issued, deal_count=0 afterward.
